// File: rtl/spi_master_arbiter_pkg.sv
// Shared SPI master types: controller state encoding and the CPOL/CPHA mode pair.
package spi_master_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_master_state_e;

  // Mode number is the {CPOL, CPHA} pair, matching the usual SPI mode 0..3 naming.
  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_e;

  function automatic spi_mode_e spi_mode(input bit cpol, input bit cpha);
    return spi_mode_e'({cpol, cpha});
  endfunction

endpackage

// File: rtl/spi_master_arbiter_rr_arbiter.sv
// Round-robin arbiter: onehot grant of the first request at or above the pointer,
// pointer advances past the winner whenever a grant is taken.
module spi_master_arbiter_rr_arbiter #(
  parameter int NumReq = 2,
  parameter int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NumReq-1:0] req,
  input  logic              en,
  output logic [NumReq-1:0] grant,
  output logic [IdxW-1:0]   grant_idx
);

  logic [IdxW-1:0] ptr;
  logic [IdxW-1:0] cand;
  logic            found;

  // NOTE: every variable gets a default before the search loop so no path leaves
  // one unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = IdxW'((int'(ptr) + k) % NumReq);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (grant_idx == IdxW'(NumReq - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// SPI master shared by NumReq clients: round-robin grant, one negss per client,
// full-duplex MSB-first frames, received word returned with a done pulse.
module spi_master_arbiter
  import spi_master_arbiter_pkg::*;
#(
  parameter int NumReq        = 2,
  parameter int ShiftRegWidth = 8,
  parameter bit CPOL          = 1'b0,
  parameter bit CPHA          = 1'b0,
  parameter int ClkDiv        = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NumReq-1:0]               req,
  input  logic [NumReq*ShiftRegWidth-1:0] req_data,
  output logic [NumReq-1:0]               ack,
  output logic [NumReq-1:0]               done,
  output logic [ShiftRegWidth-1:0]        rx_data,
  output logic                            busy,
  output logic                            sclk,
  output logic                            mosi,
  input  logic                            miso,
  output logic [NumReq-1:0]               negss
);

  localparam int W     = ShiftRegWidth;
  localparam int IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int DivW  = $clog2(ClkDiv);
  localparam int HalfW = $clog2(2 * ShiftRegWidth);

  localparam logic [DivW-1:0]  DivLast       = DivW'(ClkDiv - 1);
  localparam logic [HalfW-1:0] HalfLast      = HalfW'(2 * W - 1);
  localparam logic [HalfW-1:0] HalfLastTrail = HalfW'(2 * W - 2);

  localparam spi_mode_e Mode         = spi_mode(CPOL, CPHA);
  localparam bit        SampleOnLead = (Mode == SPI_MODE0) || (Mode == SPI_MODE2);

  if (ClkDiv < 2) begin : g_bad_clkdiv
    $error("spi_master_arbiter: ClkDiv must be at least 2");
  end
  if (NumReq < 1 || NumReq > 8) begin : g_bad_numreq
    $error("spi_master_arbiter: NumReq must be in 1..8");
  end
  if (ShiftRegWidth < 2) begin : g_bad_width
    $error("spi_master_arbiter: ShiftRegWidth must be at least 2");
  end

  spi_master_state_e state;
  logic [DivW-1:0]   cnt;
  logic [HalfW-1:0]  half;
  logic [W-1:0]      tx_sr;
  logic [W-1:0]      rx_sr;
  logic [NumReq-1:0] owner;

  logic [NumReq-1:0] grant;
  logic [IdxW-1:0]   grant_idx;
  logic [W-1:0]      sel_data;
  logic              arb_en;

  assign arb_en = (state == ST_IDLE);

  spi_master_arbiter_rr_arbiter #(
    .NumReq(NumReq),
    .IdxW  (IdxW)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .en       (arb_en),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  always_comb begin
    sel_data = req_data[0 +: W];
    for (int i = 0; i < NumReq; i++) begin
      if (grant_idx == IdxW'(i)) sel_data = req_data[i*W +: W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      half    <= '0;
      sclk    <= CPOL;
      mosi    <= 1'b0;
      negss   <= '1;
      ack     <= '0;
      done    <= '0;
      busy    <= 1'b0;
      rx_data <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      owner   <= '0;
    end else begin
      ack  <= '0;
      done <= '0;
      case (state)
        ST_IDLE: begin
          cnt  <= '0;
          half <= '0;
          if (|req) begin
            ack   <= grant;
            owner <= grant;
            negss <= ~grant;
            tx_sr <= sel_data;
            rx_sr <= '0;
            busy  <= 1'b1;
            // With leading-edge sampling the slave must see the MSB before the first edge.
            mosi  <= SampleOnLead ? sel_data[W-1] : 1'b0;
            state <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (cnt == DivLast) begin
            cnt   <= '0;
            half  <= '0;
            sclk  <= ~CPOL;
            state <= ST_SHIFT;
            if (SampleOnLead) begin
              rx_sr <= {rx_sr[W-2:0], miso};
            end else begin
              mosi  <= tx_sr[W-1];
              tx_sr <= tx_sr << 1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (cnt == DivLast) begin
            cnt <= '0;
            if (half == HalfLast) begin
              state <= ST_HOLD;
            end else begin
              half <= half + 1'b1;
              sclk <= ~sclk;
              if (half[0]) begin
                // Next half-period is even: leading edge.
                if (SampleOnLead) begin
                  rx_sr <= {rx_sr[W-2:0], miso};
                end else begin
                  mosi  <= tx_sr[W-1];
                  tx_sr <= tx_sr << 1;
                end
              end else begin
                // Next half-period is odd: trailing edge.
                if (SampleOnLead) begin
                  if (half != HalfLastTrail) begin
                    mosi  <= tx_sr[W-2];
                    tx_sr <= tx_sr << 1;
                  end
                end else begin
                  rx_sr <= {rx_sr[W-2:0], miso};
                end
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_HOLD: begin
          if (cnt == DivLast) begin
            cnt     <= '0;
            done    <= owner;
            rx_data <= rx_sr;
            negss   <= '1;
            mosi    <= 1'b0;
            state   <= ST_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_GAP: begin
          if (cnt == DivLast) begin
            cnt   <= '0;
            busy  <= 1'b0;
            owner <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
SPI master that generates sclk, mosi and one negss line per slave, and shares a single shift datapath among NumReq requesters. Requester i always targets slave i, which is selected by negss[i]. The block performs round-robin arbitration, full-duplex MSB-first frames, and returns the received word to the granted requester. It sits between on-chip clients and the pinout; the slaves are spi_controller instances, either off-chip or inside the design.

Parameters:
NumReq, 2, number of requesters and slaves (1..8)
ShiftRegWidth, 8, bits per frame
CPOL, 0, sclk idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
ClkDiv, 2, clk cycles per sclk half-period (>= 2, elaboration assertion)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous, active-high reset
req  input  NumReq  request per client; held high until ack
req_data  input  NumReq*ShiftRegWidth  tx word per client, slice i = client i
ack  output  NumReq  one-cycle pulse, onehot; req_data[i] latched this cycle
done  output  NumReq  one-cycle pulse, onehot; rx_data valid this cycle
rx_data  output  ShiftRegWidth  received word; holds until next done
busy  output  1  high from ack through end of GAP
sclk  output  1  SPI clock
mosi  output  1  master out
miso  input  1  master in
negss  output  NumReq  active-low slave selects

Behaviour:
- Reset (async, immediate): FSM=IDLE, sclk=CPOL, mosi=0, negss all 1, ack=done=0, busy=0, rx_data=0, rr pointer=0, counters=0. Reset mid-frame aborts the frame with no done and deasserts negss immediately.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: if any req, grant the first set bit searching from rr pointer upward with wrap. Same cycle: ack[g]=1, latch req_data slice into tx shift reg, busy=1. Next state SETUP. rr pointer becomes g+1 mod NumReq.
- Dropping req before ack is a legal withdrawal. req is not sampled while busy.
- SETUP: negss[g]=0 for ClkDiv cycles. If CPHA=0, mosi=tx MSB is already driven on entry.
- SHIFT: 2*ShiftRegWidth sclk half-periods of ClkDiv cycles each; sclk toggles at each half-period boundary.
- CPHA=0: sample miso on each leading edge; shift mosi on each trailing edge except the last.
- CPHA=1: shift mosi on each leading edge (the first leading edge drives the MSB); sample on each trailing edge.
- Sampled bits shift into the rx reg LSB, so the rx reg is MSB-first.
- HOLD: sclk back at CPOL, negss[g] still low for ClkDiv cycles. On the last HOLD cycle, rx_data = rx reg and done[g]=1.
- GAP: negss all 1, mosi=0 for ClkDiv cycles, then IDLE with busy=0.
- Timing: ack to done = ClkDiv*(2*ShiftRegWidth+2) cycles. Back-to-back ack spacing = ClkDiv*(2*ShiftRegWidth+3)+1 cycles.
- Exactly ShiftRegWidth sclk pulses per frame. At most one negss is low at any time, and never in IDLE.
- Bit counter width: $clog2(2*ShiftRegWidth). Half-period divider width: $clog2(ClkDiv). Both wrap only under FSM control.

Decomposition:
- spi_pkg: state enum type spi_master_state_e, constant localparam for mode encoding (CPOL/CPHA pair), shared with spi_controller users.
- Sub-module rr_arbiter (NumReq): req vector, rr pointer, enable -> onehot grant, index. Pure combinational plus pointer register.

Test Plan:
- Mode 0, ClkDiv=2, W=8, mosi looped to miso; req[0] with data 0xA5 -> ack[0] at cycle t; done[0] at t+36; rx_data=0xA5; 8 sclk rising edges; only negss[0] low.
- Both req high with 0x3C/0xC3, held high, three frames -> grant order 0,1,0; rx matches each; negss never overlap; spacing 39 cycles.
- CPOL=1, CPHA=1, behavioural slave returning 0x5A and checking it receives 0x96 -> rx_data=0x5A; sclk idles high; slave sees mosi stable at each trailing edge.
- CPHA=0 check against an spi_controller slave preloaded with 0xF0 -> master rx 0xF0; slave dOut=tx word 0x0F.
- rst pulse mid-SHIFT (bit 4) -> same-cycle sclk=CPOL, negss all 1, no done; next req completes normally with rr pointer=0.
- req[1] raised then dropped while busy on client 0 -> no ack[1]; req[1] re-raised after GAP -> ack[1] next IDLE cycle.
